// File: rtl/ir_addr_gen.sv
// -----------------------------------------------------------------------------
// ir_addr_gen
//
// Per-row input-address generator for the input router. When the controller
// raises i_ag_en for this row's id, the block latches the output coordinate
// and kernel geometry, then walks the K x K kernel window, writing one
// input-SRAM address per cycle into a local show-ahead FIFO. The tile reader
// and address comparator drain that FIFO; o_empty feeds the controller's
// i_addr_empty.
//
// Parameters:
//   ROW_COUNT   width of the row-id bus
//   ROW_ID      row id this instance responds to
//   ADDR_WIDTH  width of addresses, coordinates and sizes
//   FIFO_DEPTH  address FIFO entries (power of two, >= 2)
//
// Ports:
//   i_clk          clock
//   i_nrst         asynchronous active-low reset
//   i_reg_clear    synchronous clear, same effect as reset
//   i_ag_en        coordinate valid from the controller
//   i_row_id       row id qualifying i_ag_en
//   i_o_x, i_o_y   output coordinate (already stride-scaled)
//   i_start_addr   base address of the input tile
//   i_i_size       input feature-map row length
//   i_k_size       kernel side K
//   i_pop          consumer pop request
//   o_addr         FIFO head (show-ahead, don't-care while empty)
//   o_empty        FIFO empty
//   o_full         FIFO full
//   o_busy         generation in progress (this is the FSM state: 1 = GEN)
//   o_gen_done     one-cycle pulse after the last address is written
//   o_err          sticky: an accept arrived while generation was running
//
// Consumer handshake: o_empty low acts as "valid" and i_pop as "ready";
// an entry transfers on every rising edge where i_pop && !o_empty, after
// which o_addr shows the next entry. i_pop while empty is ignored.
// -----------------------------------------------------------------------------
module ir_addr_gen #(
    parameter int ROW_COUNT  = 4,
    parameter int ROW_ID     = 0,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_reg_clear,
    input  logic                  i_ag_en,
    input  logic [ROW_COUNT-1:0]  i_row_id,
    input  logic [ADDR_WIDTH-1:0] i_o_x,
    input  logic [ADDR_WIDTH-1:0] i_o_y,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic [ADDR_WIDTH-1:0] i_i_size,
    input  logic [ADDR_WIDTH-1:0] i_k_size,
    input  logic                  i_pop,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_busy,
    output logic                  o_gen_done,
    output logic                  o_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ROW_COUNT-1:0]  ROW_ID_V = ROW_COUNT'(ROW_ID);
    localparam logic [CNT_W-1:0]      DEPTH_V  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
    localparam logic [ADDR_WIDTH-1:0] A_ZERO   = '0;
    localparam logic [ADDR_WIDTH-1:0] A_ONE    = ADDR_WIDTH'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GEN  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   x_q;
    logic [ADDR_WIDTH-1:0]   y_q;
    logic [ADDR_WIDTH-1:0]   start_q;
    logic [ADDR_WIDTH-1:0]   isize_q;
    logic [ADDR_WIDTH-1:0]   k_q;
    logic [ADDR_WIDTH-1:0]   kx_q;
    logic [ADDR_WIDTH-1:0]   ky_q;
    logic                    gen_done_q;
    logic                    err_q;

    logic [ADDR_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [CNT_W-1:0]        count_q;

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic                  accept;
    logic                  in_gen;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] k_last;
    logic                  ky_wrap;
    logic                  window_last;
    logic [ADDR_WIDTH-1:0] row_sum;
    logic [ADDR_WIDTH-1:0] col_sum;
    logic [ADDR_WIDTH-1:0] row_offset;
    logic [ADDR_WIDTH-1:0] gen_addr;

    assign accept     = i_ag_en && (i_row_id == ROW_ID_V);
    assign in_gen     = (state_q == ST_GEN);
    assign fifo_full  = (count_q == DEPTH_V);
    assign fifo_empty = (count_q == '0);

    // Push is judged on the registered count only, so a pop in the same
    // cycle never makes room for a push while the FIFO is full.
    assign push = in_gen && !fifo_full;
    assign pop  = i_pop && !fifo_empty;

    assign k_last      = k_q - A_ONE;
    assign ky_wrap     = (ky_q == k_last);
    assign window_last = ky_wrap && (kx_q == k_last);

    // All terms are ADDR_WIDTH wide; the address wraps modulo 2^ADDR_WIDTH.
    assign row_sum    = x_q + kx_q;
    assign col_sum    = y_q + ky_q;
    assign row_offset = row_sum * isize_q;
    assign gen_addr   = start_q + row_offset + col_sum;

    // -------------------------------------------------------------------------
    // Window-walk FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            start_q    <= '0;
            isize_q    <= '0;
            k_q        <= '0;
            kx_q       <= '0;
            ky_q       <= '0;
            gen_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else if (i_reg_clear) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            start_q    <= '0;
            isize_q    <= '0;
            k_q        <= '0;
            kx_q       <= '0;
            ky_q       <= '0;
            gen_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            gen_done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        x_q     <= i_o_x;
                        y_q     <= i_o_y;
                        start_q <= i_start_addr;
                        isize_q <= i_i_size;
                        k_q     <= i_k_size;
                        kx_q    <= '0;
                        ky_q    <= '0;
                        // An empty window finishes immediately without
                        // ever entering GEN.
                        if (i_k_size == A_ZERO) begin
                            gen_done_q <= 1'b1;
                        end else begin
                            state_q <= ST_GEN;
                        end
                    end
                end
                ST_GEN: begin
                    // A second coordinate during a walk is dropped; only
                    // the sticky error records it.
                    if (accept) begin
                        err_q <= 1'b1;
                    end
                    if (push) begin
                        if (ky_wrap) begin
                            ky_q <= '0;
                            if (window_last) begin
                                kx_q       <= '0;
                                gen_done_q <= 1'b1;
                                state_q    <= ST_IDLE;
                            end else begin
                                kx_q <= kx_q + A_ONE;
                            end
                        end else begin
                            ky_q <= ky_q + A_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Address FIFO: pointers and occupancy
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_reg_clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset: its content is only observable through
    // o_addr, which is don't-care while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= gen_addr;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_addr     = mem[rd_ptr_q];
    assign o_empty    = fifo_empty;
    assign o_full     = fifo_full;
    assign o_busy     = in_gen;
    assign o_gen_done = gen_done_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_ir_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_ir_addr_gen
//
// Directed bench for ir_addr_gen (ROW_ID = 0, 8-bit addresses, 4-entry FIFO).
// Each window request pushes its hand-computed address list into exp_q; an
// independent monitor pops and compares whenever an entry leaves the FIFO.
// Inputs change 1 time unit after the rising edge; the monitor samples on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_ir_addr_gen;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          nrst;
    logic          reg_clear;
    logic          ag_en;
    logic [3:0]    row_id;
    logic [AW-1:0] o_x;
    logic [AW-1:0] o_y;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] i_size;
    logic [AW-1:0] k_size;
    logic          pop;
    logic [AW-1:0] addr;
    logic          empty;
    logic          full;
    logic          busy;
    logic          gen_done;
    logic          err;

    ir_addr_gen #(
        .ROW_COUNT  (4),
        .ROW_ID     (0),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_nrst       (nrst),
        .i_reg_clear  (reg_clear),
        .i_ag_en      (ag_en),
        .i_row_id     (row_id),
        .i_o_x        (o_x),
        .i_o_y        (o_y),
        .i_start_addr (start_addr),
        .i_i_size     (i_size),
        .i_k_size     (k_size),
        .i_pop        (pop),
        .o_addr       (addr),
        .o_empty      (empty),
        .o_full       (full),
        .o_busy       (busy),
        .o_gen_done   (gen_done),
        .o_err        (err)
    );

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_v;

    // start=0x10, i_size=5, K=3, (x,y)=(2,1):
    // 0x10 + (2+kx)*5 + (1+ky)
    logic [AW-1:0] basic_exp [9] = '{8'h1B, 8'h1C, 8'h1D,
                                     8'h20, 8'h21, 8'h22,
                                     8'h25, 8'h26, 8'h27};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: an entry leaves on the next rising edge when pop && !empty.
    always @(negedge clk) begin
        if (nrst && pop && !empty) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no entry (t=%0t)", addr, $time);
            end else begin
                exp_v = exp_q.pop_front();
                chk("pop_addr", 32'(addr), 32'(exp_v));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reg_clear  = 1'b0;
        ag_en      = 1'b0;
        row_id     = '0;
        o_x        = '0;
        o_y        = '0;
        start_addr = '0;
        i_size     = '0;
        k_size     = '0;
        pop        = 1'b0;
    endtask

    task automatic request(input logic [3:0] rid, input logic [AW-1:0] x, input logic [AW-1:0] y,
                           input logic [AW-1:0] st, input logic [AW-1:0] isz, input logic [AW-1:0] k);
        row_id     = rid;
        o_x        = x;
        o_y        = y;
        start_addr = st;
        i_size     = isz;
        k_size     = k;
        ag_en      = 1'b1;
        tick();
        ag_en      = 1'b0;
    endtask

    task automatic push_basic();
        for (int i = 0; i < 9; i++) exp_q.push_back(basic_exp[i]);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!gen_done && n < 100) begin
            tick();
            n++;
        end
        chk(name, 32'(gen_done), 32'd1);
    endtask

    task automatic wait_drained(input string name);
        int n;
        n = 0;
        while (!empty && n < 100) begin
            tick();
            n++;
        end
        chk(name, 32'(empty), 32'd1);
        chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        idle_inputs();
        nrst = 1'b0;
        tick();
        tick();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(gen_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        nrst = 1'b1;
        tick();

        // Basic window with the consumer always ready.
        pop = 1'b1;
        push_basic();
        request(4'd0, 8'd2, 8'd1, 8'h10, 8'd5, 8'd3);
        chk("basic_busy_after_accept", 32'(busy), 32'd1);
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("basic_done_timing", 32'(gen_done), 32'(i == 9));
            chk("basic_busy_timing", 32'(busy), 32'(i != 9));
        end
        tick();
        chk("basic_done_single_pulse", 32'(gen_done), 32'd0);
        wait_drained("basic_drain");
        pop = 1'b0;

        // Backpressure: no pops until the FIFO fills and the walk stalls.
        push_basic();
        request(4'd0, 8'd2, 8'd1, 8'h10, 8'd5, 8'd3);
        repeat (4) tick();
        chk("bp_full_after_4", 32'(full), 32'd1);
        repeat (3) tick();
        chk("bp_full_held", 32'(full), 32'd1);
        chk("bp_busy_held", 32'(busy), 32'd1);
        chk("bp_no_done", 32'(gen_done), 32'd0);
        pop = 1'b1;
        wait_done("bp_done");
        wait_drained("bp_drain");
        pop = 1'b0;

        // Row filtering: another row's id is ignored.
        request(4'd1, 8'd2, 8'd1, 8'h10, 8'd5, 8'd3);
        chk("row_filter_busy", 32'(busy), 32'd0);
        tick();
        chk("row_filter_empty", 32'(empty), 32'd1);
        chk("row_filter_done", 32'(gen_done), 32'd0);

        // Accept while busy: error set, stream unchanged.
        pop = 1'b1;
        push_basic();
        request(4'd0, 8'd2, 8'd1, 8'h10, 8'd5, 8'd3);
        repeat (2) tick();
        request(4'd0, 8'd4, 8'd4, 8'h80, 8'd2, 8'd2);
        chk("err_set", 32'(err), 32'd1);
        chk("err_busy", 32'(busy), 32'd1);
        wait_done("err_done");
        wait_drained("err_drain");
        chk("err_sticky", 32'(err), 32'd1);
        pop = 1'b0;

        // Synchronous clear with a full FIFO and the error still set.
        request(4'd0, 8'd2, 8'd1, 8'h10, 8'd5, 8'd3);
        repeat (6) tick();
        chk("clr_full_before", 32'(full), 32'd1);
        reg_clear = 1'b1;
        tick();
        reg_clear = 1'b0;
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_empty", 32'(empty), 32'd1);
        chk("clr_full", 32'(full), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("clr_no_writes", 32'(empty), 32'd1);

        // K = 0: done next cycle, nothing written.
        request(4'd0, 8'd2, 8'd1, 8'h10, 8'd5, 8'd0);
        chk("k0_done", 32'(gen_done), 32'd1);
        chk("k0_busy", 32'(busy), 32'd0);
        chk("k0_empty", 32'(empty), 32'd1);
        tick();
        chk("k0_done_clears", 32'(gen_done), 32'd0);
        chk("k0_empty_after", 32'(empty), 32'd1);

        // K = 1 with address wrap: 0xF0 + 2*8 + 0 = 0x100 -> 0x00.
        exp_q.push_back(8'h00);
        request(4'd0, 8'd2, 8'd0, 8'hF0, 8'd8, 8'd1);
        chk("wrap_busy", 32'(busy), 32'd1);
        tick();
        chk("wrap_done", 32'(gen_done), 32'd1);
        chk("wrap_not_empty", 32'(empty), 32'd0);
        chk("wrap_busy_fall", 32'(busy), 32'd0);
        pop = 1'b1;
        wait_drained("wrap_drain");

        // Pop on empty is ignored.
        repeat (3) tick();
        chk("pop_empty_empty", 32'(empty), 32'd1);
        chk("pop_empty_full", 32'(full), 32'd0);
        pop = 1'b0;

        // Simultaneous push and pop at count 2 keeps count at 2:
        // full must appear exactly two pushes later.
        push_basic();
        request(4'd0, 8'd2, 8'd1, 8'h10, 8'd5, 8'd3);
        tick();
        tick();
        chk("pp_not_empty", 32'(empty), 32'd0);
        chk("pp_not_full", 32'(full), 32'd0);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        tick();
        chk("pp_count3_not_full", 32'(full), 32'd0);
        tick();
        chk("pp_count4_full", 32'(full), 32'd1);
        pop = 1'b1;
        wait_done("pp_done");
        wait_drained("pp_drain");
        pop = 1'b0;

        // Asynchronous reset mid-generation, with the error flag set.
        request(4'd0, 8'd2, 8'd1, 8'h10, 8'd5, 8'd3);
        tick();
        request(4'd0, 8'd1, 8'd1, 8'h20, 8'd3, 8'd2);
        chk("rst2_err_before", 32'(err), 32'd1);
        #1;
        nrst = 1'b0;
        #1;
        exp_q.delete();
        chk("rst2_empty", 32'(empty), 32'd1);
        chk("rst2_full", 32'(full), 32'd0);
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_done", 32'(gen_done), 32'd0);
        chk("rst2_err", 32'(err), 32'd0);
        tick();
        nrst = 1'b1;
        repeat (4) tick();
        chk("rst2_empty_after", 32'(empty), 32'd1);
        chk("rst2_busy_after", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
